multicycle_control_unit: RTL and testbench

- Moore-style sequencing FSM for the multi-cycle variant of the 32-bit MIPS core.
- Steps a shared datapath through fetch, decode, execute, memory and writeback. A single ALU and a single unified instruction/data memory are reused across cycles.
- Sits beside the datapath. It takes Opcode, Funct and Zero from the datapath and drives every mux select, write enable and ALU operation.
- Also keeps a retired-instruction counter and flags illegal opcodes.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_control_unit.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// States, opcodes, funct codes and datapath select values.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECUTE  = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_ADDIEX   = 4'd10,
      S_ADDIWB   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: ALUOp from the FSM plus Funct
// select the ALUControl code driven to the datapath ALU.
module alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int FUNCT_WIDTH = 6
) (
   input  logic [FUNCT_WIDTH-1:0] funct,
   input  logic [1:0]             aluop,
   output logic [2:0]             alucontrol
);

   // Fixed add/sub from the FSM, otherwise decode funct
   always_comb begin
      alucontrol = ALU_ADD;
      unique case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            unique case (funct)
               F_ADD:   alucontrol = ALU_ADD;
               F_SUB:   alucontrol = ALU_SUB;
               F_AND:   alucontrol = ALU_AND;
               F_OR:    alucontrol = ALU_OR;
               F_SLT:   alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencing FSM for the multi-cycle MIPS datapath,
// with retired-instruction counter and illegal-op flag.
module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_WIDTH = 6,
   parameter int FUNCT_WIDTH  = 6,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                    CLK,
   input  logic                    rst,
   input  logic [OPCODE_WIDTH-1:0] Opcode,
   input  logic [FUNCT_WIDTH-1:0]  Funct,
   input  logic                    Zero,
   output logic                    IorD,
   output logic                    MemWrite,
   output logic                    IRWrite,
   output logic                    RegDst,
   output logic                    MemtoReg,
   output logic                    RegWrite,
   output logic                    ALUSrcA,
   output logic [1:0]              ALUSrcB,
   output logic [2:0]              ALUControl,
   output logic [1:0]              PCSrc,
   output logic                    PCEn,
   output logic                    IllegalOp,
   output logic [COUNT_WIDTH-1:0]  InstrCount,
   output logic [3:0]              State
);

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

   state_t     state;
   state_t     next;
   logic       pcwrite;
   logic       branch;
   logic       aluen;
   logic [1:0] aluop;
   logic [2:0] dec_ctl;
   logic       retire;

   alu_decoder #(
      .FUNCT_WIDTH(FUNCT_WIDTH)
   ) u_aludec (
      .funct      (Funct),
      .aluop      (aluop),
      .alucontrol (dec_ctl)
   );

   assign retire = (state == S_MEMWB)  || (state == S_MEMWRITE) ||
                   (state == S_ALUWB)  || (state == S_ADDIWB)   ||
                   (state == S_BRANCH) || (state == S_JUMP);

   assign ALUControl = aluen ? dec_ctl : 3'b000;
   assign PCEn       = pcwrite | (branch & Zero);
   assign State      = state;

   // State register
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) state <= S_RESET;
      else      state <= next;
   end

   // Count instructions as they leave their final state
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst)        InstrCount <= '0;
      else if (retire) InstrCount <= InstrCount + CNT_ONE;
   end

   // Next-state and per-state Moore outputs
   always_comb begin
      next      = state;
      IorD      = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_REG;
      PCSrc     = PC_ALU;
      pcwrite   = 1'b0;
      branch    = 1'b0;
      aluen     = 1'b0;
      aluop     = ALUOP_ADD;
      IllegalOp = 1'b0;
      unique case (state)
         S_RESET: next = S_FETCH;
         S_FETCH: begin
            IRWrite = 1'b1;
            ALUSrcB = SRCB_FOUR;
            aluen   = 1'b1;
            pcwrite = 1'b1;
            next    = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            aluen   = 1'b1;
            unique case (Opcode)
               OP_LW, OP_SW: next = S_MEMADR;
               OP_RTYPE:     next = S_EXECUTE;
               OP_BEQ:       next = S_BRANCH;
               OP_ADDI:      next = S_ADDIEX;
               OP_J:         next = S_JUMP;
               default: begin
                  next      = S_FETCH;
                  IllegalOp = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            aluen   = 1'b1;
            next    = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            IorD = 1'b1;
            next = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            next     = S_FETCH;
         end
         S_MEMWRITE: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            next     = S_FETCH;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            aluen   = 1'b1;
            aluop   = ALUOP_FUNCT;
            next    = S_ALUWB;
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            next     = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            aluen   = 1'b1;
            aluop   = ALUOP_SUB;
            PCSrc   = PC_ALUOUT;
            branch  = 1'b1;
            next    = S_FETCH;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            aluen   = 1'b1;
            next    = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite = 1'b1;
            next     = S_FETCH;
         end
         S_JUMP: begin
            PCSrc   = PC_JUMP;
            pcwrite = 1'b1;
            next    = S_FETCH;
         end
         default: next = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Hand-computed state/output vectors per instruction.
module tb_multicycle_control_unit;

   logic        CLK = 1'b0;
   logic        rst;
   logic [5:0]  Opcode;
   logic [5:0]  Funct;
   logic        Zero;
   logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
   logic        ALUSrcA, PCEn, IllegalOp;
   logic [1:0]  ALUSrcB, PCSrc;
   logic [2:0]  ALUControl;
   logic [31:0] InstrCount;
   logic [3:0]  State;

   int checks = 0;
   int failures = 0;

   multicycle_control_unit dut (
      .CLK        (CLK),
      .rst        (rst),
      .Opcode     (Opcode),
      .Funct      (Funct),
      .Zero       (Zero),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .PCSrc      (PCSrc),
      .PCEn       (PCEn),
      .IllegalOp  (IllegalOp),
      .InstrCount (InstrCount),
      .State      (State)
   );

   always #5 CLK = ~CLK;

   // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,
   //  ALUSrcA,ALUSrcB[2],ALUControl[3],PCSrc[2],PCEn,IllegalOp}
   logic [15:0] outs;
   assign outs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, IllegalOp};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Advance one edge and check state plus full output vector
   task automatic step(input string tag, input logic [3:0] st,
                       input logic [15:0] ov);
      tick();
      chk({tag, ".state"}, 32'(State), 32'(st));
      chk({tag, ".outs"}, 32'(outs), 32'(ov));
   endtask

   //                       I M I R M R A SB  CTL PC P I
   localparam logic [15:0] O_FETCH  = 16'b0_0_1_0_0_0_0_01_010_00_1_0;
   localparam logic [15:0] O_DECODE = 16'b0_0_0_0_0_0_0_11_010_00_0_0;
   localparam logic [15:0] O_MEMADR = 16'b0_0_0_0_0_0_1_10_010_00_0_0;
   localparam logic [15:0] O_MEMRD  = 16'b1_0_0_0_0_0_0_00_000_00_0_0;
   localparam logic [15:0] O_MEMWB  = 16'b0_0_0_0_1_1_0_00_000_00_0_0;
   localparam logic [15:0] O_MEMWR  = 16'b1_1_0_0_0_0_0_00_000_00_0_0;
   localparam logic [15:0] O_ALUWB  = 16'b0_0_0_1_0_1_0_00_000_00_0_0;
   localparam logic [15:0] O_BR_T   = 16'b0_0_0_0_0_0_1_00_110_01_1_0;
   localparam logic [15:0] O_BR_N   = 16'b0_0_0_0_0_0_1_00_110_01_0_0;
   localparam logic [15:0] O_ADDIEX = 16'b0_0_0_0_0_0_1_10_010_00_0_0;
   localparam logic [15:0] O_ADDIWB = 16'b0_0_0_0_0_1_0_00_000_00_0_0;
   localparam logic [15:0] O_JUMP   = 16'b0_0_0_0_0_0_0_00_000_10_1_0;
   localparam logic [15:0] O_ILL    = 16'b0_0_0_0_0_0_0_11_010_00_0_1;

   logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b101010, 6'b111111};
   logic [2:0] ctl_tab [6] = '{3'b010, 3'b110, 3'b000,
                               3'b001, 3'b111, 3'b010};

   initial begin
      rst    = 1'b0;
      Opcode = 6'b000000;
      Funct  = 6'b000000;
      Zero   = 1'b0;

      repeat (3) tick();
      chk("rst.state", 32'(State), 32'd0);
      chk("rst.outs", 32'(outs), 32'd0);
      chk("rst.count", InstrCount, 32'd0);

      rst = 1'b1;
      Opcode = 6'b100011;
      step("fetch0", 4'd1, O_FETCH);
      chk("fetch0.count", InstrCount, 32'd0);

      // lw
      step("lw.dec", 4'd2, O_DECODE);
      step("lw.adr", 4'd3, O_MEMADR);
      step("lw.rd", 4'd4, O_MEMRD);
      step("lw.wb", 4'd5, O_MEMWB);
      chk("lw.cnt_pre", InstrCount, 32'd0);
      step("lw.fetch", 4'd1, O_FETCH);
      chk("lw.cnt", InstrCount, 32'd1);

      // R-type across funct table, slt included
      Opcode = 6'b000000;
      for (int i = 0; i < 6; i++) begin
         Funct = fn_tab[i];
         step("r.dec", 4'd2, O_DECODE);
         step("r.ex", 4'd7, {7'b0000001, 2'b00, ctl_tab[i], 4'b0000});
         step("r.wb", 4'd8, O_ALUWB);
         step("r.fetch", 4'd1, O_FETCH);
         chk("r.cnt", InstrCount, 32'(2 + i));
      end

      // beq taken, with Zero dropping inside BRANCH
      Opcode = 6'b000100;
      Zero = 1'b1;
      step("beq1.dec", 4'd2, O_DECODE);
      step("beq1.br", 4'd9, O_BR_T);
      Zero = 1'b0;
      #1;
      chk("beq1.pcen_comb", 32'(PCEn), 32'd0);
      Zero = 1'b1;
      #1;
      chk("beq1.pcen_back", 32'(PCEn), 32'd1);
      step("beq1.fetch", 4'd1, O_FETCH);
      chk("beq1.cnt", InstrCount, 32'd8);
      Zero = 1'b0;
      step("beq2.dec", 4'd2, O_DECODE);
      step("beq2.br", 4'd9, O_BR_N);
      step("beq2.fetch", 4'd1, O_FETCH);
      chk("beq2.cnt", InstrCount, 32'd9);

      // addi
      Opcode = 6'b001000;
      step("addi.dec", 4'd2, O_DECODE);
      step("addi.ex", 4'd10, O_ADDIEX);
      step("addi.wb", 4'd11, O_ADDIWB);
      step("addi.fetch", 4'd1, O_FETCH);
      chk("addi.cnt", InstrCount, 32'd10);

      // j
      Opcode = 6'b000010;
      step("j.dec", 4'd2, O_DECODE);
      step("j.jump", 4'd12, O_JUMP);
      step("j.fetch", 4'd1, O_FETCH);
      chk("j.cnt", InstrCount, 32'd11);

      // illegal opcode
      Opcode = 6'b111111;
      step("ill.dec", 4'd2, O_ILL);
      step("ill.fetch", 4'd1, O_FETCH);
      chk("ill.cnt", InstrCount, 32'd11);

      // sw with reset asserted inside MEMWRITE
      Opcode = 6'b101011;
      step("sw.dec", 4'd2, O_DECODE);
      step("sw.adr", 4'd3, O_MEMADR);
      step("sw.wr", 4'd6, O_MEMWR);
      #2;
      rst = 1'b0;
      #1;
      chk("swrst.state", 32'(State), 32'd0);
      chk("swrst.outs", 32'(outs), 32'd0);
      chk("swrst.count", InstrCount, 32'd0);
      tick();
      chk("swrst.hold", 32'(State), 32'd0);
      rst = 1'b1;
      step("swrst.fetch", 4'd1, O_FETCH);
      chk("swrst.cnt", InstrCount, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
